// File: rtl/fwd_pkg.sv
// Purpose: shared constants for the forwarding-unit compare logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fwd_pkg;

   // Width of a register-index field compared by the forwarding unit.
   localparam int REG_IDX_W = 2;

endpackage : fwd_pkg

// File: rtl/equal_bit.sv
// Purpose: 1-bit equality cell (XNOR) used to build the field comparator.
// Latency: combinational, zero cycles.
// Backpressure: none; always accepts and always produces.
module equal_bit (
   input  logic a,
   input  logic b,
   output logic eq
);

   // X/Z on either input propagates to eq; nothing here masks unknowns.
   assign eq = ~(a ^ b);

endmodule : equal_bit

// File: rtl/fwd_equal_2bit.sv
// Purpose: register-index equality compare for forwarding, with per-bit diff and a registered match.
// Latency: Out/diff combinational (0 cycles); out_q one cycle behind Out.
// Backpressure: none; samples inputs every cycle, out_q has no enable.
module fwd_equal_2bit
   import fwd_pkg::*;
#(
   parameter int WIDTH = REG_IDX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             Out,
   output logic [WIDTH-1:0] diff,
   output logic             out_q
);

   logic [WIDTH-1:0] eq_bits;
   logic             out_d;

   // One XNOR cell per bit; the cells carry the equality, diff is their complement.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      equal_bit u_equal_bit (
         .a  (x[i]),
         .b  (y[i]),
         .eq (eq_bits[i])
      );
   end

   // Mismatch vector is exactly the inverted cell outputs, i.e. x ^ y per bit.
   assign diff = ~eq_bits;

   // AND of all cell outputs == NOR of diff; independent of clk and reset.
   assign Out = &eq_bits;

   // Next value of the registered match is simply the current combinational match.
   always_comb begin
      out_d = Out;
   end

   // Registered match for stages that need last cycle's compare; reset wins over a coincident edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q <= 1'b0;
      end else begin
         out_q <= out_d;
      end
   end

endmodule : fwd_equal_2bit

// File: tb/tb_fwd_equal_2bit.sv
// Purpose: directed self-checking bench for fwd_equal_2bit.
// Latency: checks Out/diff 1 time unit after input change, out_q 1 time unit after posedge.
// Backpressure: n/a.
module tb_fwd_equal_2bit;

   logic       clk;
   logic       reset;
   logic [1:0] x;
   logic [1:0] y;
   logic       Out;
   logic [1:0] diff;
   logic       out_q;

   logic       clk_en;
   int         tests_run;
   int         tests_failed;

   fwd_equal_2bit #(.WIDTH(2)) dut (
      .clk   (clk),
      .reset (reset),
      .x     (x),
      .y     (y),
      .Out   (Out),
      .diff  (diff),
      .out_q (out_q)
   );

   // Clock toggles only while clk_en is set so the first checks run with an idle clock.
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   initial begin
      logic [1:0] xv;
      logic [1:0] yv;
      tests_run    = 0;
      tests_failed = 0;
      clk_en       = 1'b0;
      clk          = 1'b0;
      reset        = 1'b0;

      // Combinational compare with the clock idle and reset never asserted.
      x = 2'b00; y = 2'b00; #1;
      check("idle_00_00_out",  {31'd0, Out}, 32'd1);
      check("idle_00_00_diff", {30'd0, diff}, 32'd0);
      x = 2'b00; y = 2'b01; #1;
      check("00_01_out",  {31'd0, Out}, 32'd0);
      check("00_01_diff", {30'd0, diff}, 32'd1);
      x = 2'b01; y = 2'b00; #1;
      check("01_00_out",  {31'd0, Out}, 32'd0);
      check("01_00_diff", {30'd0, diff}, 32'd1);
      x = 2'b11; y = 2'b11; #1;
      check("11_11_out",  {31'd0, Out}, 32'd1);
      check("11_11_diff", {30'd0, diff}, 32'd0);

      // Full sweep of all operand pairs.
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            xv = 2'(i); yv = 2'(j);
            x = xv; y = yv; #1;
            check($sformatf("sweep_out_%0d_%0d", i, j),  {31'd0, Out},  (i == j) ? 32'd1 : 32'd0);
            check($sformatf("sweep_diff_%0d_%0d", i, j), {30'd0, diff}, {30'd0, xv ^ yv});
         end
      end

      // Reset held: out_q cleared at once and clock edges are ignored.
      x = 2'b10; y = 2'b10;
      reset = 1'b1; #1;
      check("reset_out_q", {31'd0, out_q}, 32'd0);
      check("reset_out_unaffected", {31'd0, Out}, 32'd1);
      clk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold_out_q", {31'd0, out_q}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("release_before_edge", {31'd0, out_q}, 32'd0);
      @(posedge clk); #1;
      check("first_capture", {31'd0, out_q}, 32'd1);

      // Clocked sequence: out_q follows Out one cycle later.
      @(negedge clk); x = 2'b01; y = 2'b10;
      @(posedge clk); #1;
      check("seq_prime", {31'd0, out_q}, 32'd0);
      @(negedge clk); x = 2'b00; y = 2'b00;
      #1 check("seq0_out_q_lag", {31'd0, out_q}, 32'd0);
      @(posedge clk); #1;
      check("seq0_out_q", {31'd0, out_q}, 32'd1);
      @(negedge clk); x = 2'b00; y = 2'b01;
      #1 check("seq1_out_q_lag", {31'd0, out_q}, 32'd1);
      @(posedge clk); #1;
      check("seq1_out_q", {31'd0, out_q}, 32'd0);
      @(negedge clk); x = 2'b11; y = 2'b11;
      #1 check("seq2_out_q_lag", {31'd0, out_q}, 32'd0);
      @(posedge clk); #1;
      check("seq2_out_q", {31'd0, out_q}, 32'd1);

      // Mid-cycle reset: out_q drops immediately, Out untouched.
      #1 reset = 1'b1;
      #1;
      check("midcycle_reset_out_q", {31'd0, out_q}, 32'd0);
      check("midcycle_reset_out",   {31'd0, Out},   32'd1);
      @(posedge clk); #1;
      check("midcycle_reset_edge_ignored", {31'd0, out_q}, 32'd0);
      reset = 1'b0;
      clk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_fwd_equal_2bit
